// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: streams (sample, coefficient) operand pairs to a downstream MAC.
// Define FIR_TAP_SEQUENCER_COEF_RD_EN to add a registered coefficient read port.
module fir_tap_sequencer #(
    parameter int TAPS = 8,
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 s_valid_i,
    input  logic signed [23:0]   s_data_i,
    output logic                 s_ready_o,
    input  logic                 coef_we_i,
    input  logic [AW-1:0]        coef_addr_i,
    input  logic signed [17:0]   coef_data_i,
`ifdef FIR_TAP_SEQUENCER_COEF_RD_EN
    input  logic [AW-1:0]        coef_rd_addr_i,
    output logic signed [17:0]   coef_rd_data_o,
`endif
    output logic signed [23:0]   a_o,
    output logic signed [17:0]   b_o,
    output logic                 clear_o,
    output logic                 res_valid_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_W = (AW + 1)'(TAPS);

    state_e               state_q, state_d;
    logic [AW-1:0]        k_q, k_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic                 drain_q, drain_d;
    logic                 clr_q, clr_d;
    logic signed [23:0]   dline_q [TAPS];
    logic signed [23:0]   dline_d [TAPS];
    logic signed [17:0]   coef_q [TAPS];
    logic signed [17:0]   coef_d [TAPS];
    logic                 ready;
    logic                 accept;
    logic                 coef_ok;
    logic                 in_run;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        drain_d  = drain_q;
        dline_d  = dline_q;
        coef_d   = coef_q;
        ready    = (state_q == IDLE) || (state_q == DRAIN && drain_q);
        accept   = ready && s_valid_i;
        coef_ok  = ready && coef_we_i && ({1'b0, coef_addr_i} < TAPS_W);
        // clear lands on the accumulate stage one cycle behind k=0
        clr_d    = (state_q == RUN) && (k_q == '0);

        if (coef_ok) begin
            coef_d[coef_addr_i] = coef_data_i;
        end

        case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                if (k_q == LAST) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    k_d      = k_q + 1'b1;
                    rd_ptr_d = (rd_ptr_q == '0) ? LAST : rd_ptr_q - 1'b1;
                end
            end
            DRAIN: begin
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            dline_d[wr_ptr_q] = s_data_i;
            rd_ptr_d          = wr_ptr_q;
            wr_ptr_d          = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            k_d               = '0;
            state_d           = RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            k_q      <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            drain_q  <= 1'b0;
            clr_q    <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                dline_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            drain_q  <= drain_d;
            clr_q    <= clr_d;
            dline_q  <= dline_d;
            coef_q   <= coef_d;
        end
    end

    // outputs are gated so they read 0 for the whole time reset is held
    assign in_run      = rst_ni && (state_q == RUN);
    assign a_o         = in_run ? dline_q[rd_ptr_q] : '0;
    assign b_o         = in_run ? coef_q[k_q] : '0;
    assign clear_o     = rst_ni && clr_q;
    assign res_valid_o = rst_ni && (state_q == DRAIN) && drain_q;
    assign s_ready_o   = rst_ni && ready;

`ifdef FIR_TAP_SEQUENCER_COEF_RD_EN
    logic signed [17:0] coef_rd_q, coef_rd_d;

    always_comb begin
        coef_rd_d = '0;
        if ({1'b0, coef_rd_addr_i} < TAPS_W) begin
            coef_rd_d = coef_q[coef_rd_addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            coef_rd_q <= '0;
        end else begin
            coef_rd_q <= coef_rd_d;
        end
    end

    assign coef_rd_data_o = rst_ni ? coef_rd_q : '0;
`endif

endmodule
